// File: rtl/mmio_uart_tx_if.sv
// Load/store port between the core's data-memory path and the UART
// transmitter. The core drives the strobe, address and store data; the
// UART returns load data combinationally.
interface mmio_uart_tx_if;
  logic        sel;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output sel, output we, output a, output wd, input rd);
  modport slave  (input sel, input we, input a, input wd, output rd);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA are queued in a small
// FIFO; a bit-timing FSM drains the FIFO LSB first on txd. Loads return the
// status and baud-divider registers with no wait states.
module mmio_uart_tx #(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd433
) (
  input  logic               clk,
  input  logic               reset,
  mmio_uart_tx_if.slave      bus,
  output logic               txd,
  output logic               busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          txd_r, txd_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic [15:0]   cnt_r, cnt_nxt_s;
  logic [2:0]    bit_idx_r, bit_idx_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s;
  logic          pop_s;

  logic [7:0]    fifo_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic [15:0]   baud_div_r;

  logic          full_s, empty_s;
  logic          push_req_s, push_s, ovf_set_s, ovf_clr_s, baud_wr_s;
  logic [31:0]   rd_s;
  logic          unused_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == CW'(0));

  assign unused_s = &{1'b0, bus.a[31:4], bus.a[1:0], bus.wd[31:16]};

  // Decode stores into FIFO push, overflow clear and divider update.
  always_comb begin
    push_req_s = 1'b0;
    ovf_clr_s  = 1'b0;
    baud_wr_s  = 1'b0;
    if (bus.sel && bus.we) begin
      case (bus.a[3:2])
        2'b00:   push_req_s = 1'b1;
        2'b01:   ovf_clr_s  = bus.wd[3];
        2'b10:   baud_wr_s  = 1'b1;
        default: push_req_s = 1'b0;
      endcase
    end else begin
      push_req_s = 1'b0;
    end
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_s    = push_req_s & (~full_s | pop_s);
    ovf_set_s = push_req_s & full_s & ~pop_s;
  end

  // Next-state and next-output logic for the bit-timing FSM.
  always_comb begin
    state_nxt_s   = state_r;
    txd_nxt_s     = txd_r;
    busy_nxt_s    = busy_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = fifo_mem_r[rd_ptr_r];
          txd_nxt_s   = 1'b0;
          cnt_nxt_s   = baud_div_r;
          busy_nxt_s  = 1'b1;
          state_nxt_s = START;
        end else begin
          txd_nxt_s  = 1'b1;
          busy_nxt_s = 1'b0;
        end
      end
      START: begin
        if (cnt_r != 16'd0) begin
          cnt_nxt_s = cnt_r - 16'd1;
        end else begin
          cnt_nxt_s     = baud_div_r;
          txd_nxt_s     = shift_r[0];
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = DATA;
        end
      end
      DATA: begin
        if (cnt_r != 16'd0) begin
          cnt_nxt_s = cnt_r - 16'd1;
        end else if (bit_idx_r == 3'd7) begin
          cnt_nxt_s   = baud_div_r;
          txd_nxt_s   = 1'b1;
          state_nxt_s = STOP;
        end else begin
          cnt_nxt_s     = baud_div_r;
          shift_nxt_s   = {1'b0, shift_r[7:1]};
          txd_nxt_s     = shift_r[1];
          bit_idx_nxt_s = bit_idx_r + 3'd1;
        end
      end
      STOP: begin
        if (cnt_r != 16'd0) begin
          cnt_nxt_s = cnt_r - 16'd1;
        end else if (!empty_s) begin
          // Chain straight into the next start bit without an idle cycle.
          pop_s       = 1'b1;
          shift_nxt_s = fifo_mem_r[rd_ptr_r];
          txd_nxt_s   = 1'b0;
          cnt_nxt_s   = baud_div_r;
          state_nxt_s = START;
        end else begin
          txd_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        txd_nxt_s   = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state and serialiser registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      txd_r     <= txd_nxt_s;
      busy_r    <= busy_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // FIFO pointers/occupancy, sticky overflow flag and baud divider.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      ovf_r      <= 1'b0;
      baud_div_r <= BAUD_DIV_RST;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // A fresh overflow outranks a simultaneous clear.
      if (ovf_set_s)      ovf_r <= 1'b1;
      else if (ovf_clr_s) ovf_r <= 1'b0;
      if (baud_wr_s) baud_div_r <= bus.wd[15:0];
    end
  end

  // FIFO storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push_s && reset) begin
      fifo_mem_r[wr_ptr_r] <= bus.wd[7:0];
    end
  end

  // Combinational load data so a load completes in the same core cycle.
  always_comb begin
    rd_s = 32'd0;
    if (bus.sel) begin
      case (bus.a[3:2])
        2'b01:   rd_s = {28'd0, ovf_r, busy_r, empty_s, full_s};
        2'b10:   rd_s = {16'd0, baud_div_r};
        default: rd_s = 32'd0;
      endcase
    end else begin
      rd_s = 32'd0;
    end
  end

  assign bus.rd = rd_s;
  assign txd    = txd_r;
  assign busy   = busy_r;

endmodule
